// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU request scheduler.
// Contents:
//   StIdle/StIssue/StWait/StResp : scheduler FSM state encodings
//   CMD_MUL_INC/CMD_MUL_SHIFT    : the two multiply commands (valid when mode=1)
//   lat_sel()                    : ALU latency for a given mode/cmd
package alu_sched_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic [3:0] CMD_MUL_INC   = 4'd9;
    localparam logic [3:0] CMD_MUL_SHIFT = 4'd10;

    // cmd is zero-extended by the caller so any CMD_WIDTH up to 16 compares correctly.
    function automatic logic [2:0] lat_sel(input logic        mode,
                                           input logic [15:0] cmd,
                                           input int unsigned alu_lat,
                                           input int unsigned mul_lat);
        if (mode && (cmd == 16'(CMD_MUL_INC) || cmd == 16'(CMD_MUL_SHIFT))) begin
            return 3'(mul_lat);
        end
        return 3'(alu_lat);
    endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts just after ptr and wraps, so the
// requester granted last has the lowest priority. ptr is held by the parent.
// Ports:
//   req       : request vector
//   ptr       : index of the most recently served requester
//   enable    : gates the grant; zero grant when low
//   grant     : one-hot grant (or zero)
//   grant_idx : index of the granted requester (0 when no grant)
module alu_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (enable) begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                if (!found && req[(32'(ptr) + k) % NUM_REQ]) begin
                    found     = 1'b1;
                    grant_idx = IDX_W'((32'(ptr) + k) % NUM_REQ);
                end
            end
            grant[grant_idx] = found;
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between NUM_REQ requesters. One operation is in flight at a time:
// IDLE grants round-robin, ISSUE pulses alu_ce for one cycle, WAIT counts the
// command-dependent latency while the ALU ports hold, RESP presents the captured result.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid/req_ready              : per-requester handshake (ready is one-hot or zero)
//   req_opa/opb/cmd/mode/cin         : packed per-requester operation fields
//   alu_ce/inp_valid/opa/opb/cmd/mode/cin, alu_res : ALU interface
//   resp_valid/resp_ready/resp_id/resp_data        : result handshake
// Optional (define ALU_SCHED_PERF_EN): perf_ops, perf_stall 32-bit wrapping counters.
module alu_req_scheduler
    import alu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CMD_WIDTH  = 4,
    parameter int unsigned ALU_LAT    = 1,
    parameter int unsigned MUL_LAT    = 2,
    localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opa,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opb,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]    req_cmd,
    input  logic [NUM_REQ-1:0]              req_mode,
    input  logic [NUM_REQ-1:0]              req_cin,
    output logic                            alu_ce,
    output logic [1:0]                      alu_inp_valid,
    output logic [DATA_WIDTH-1:0]           alu_opa,
    output logic [DATA_WIDTH-1:0]           alu_opb,
    output logic [CMD_WIDTH-1:0]            alu_cmd,
    output logic                            alu_mode,
    output logic                            alu_cin,
    input  logic [2*DATA_WIDTH-1:0]         alu_res,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [IDX_W-1:0]                resp_id,
    output logic [2*DATA_WIDTH-1:0]         resp_data
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [31:0]                     perf_ops,
    output logic [31:0]                     perf_stall
`endif
);

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, idx_q, id_q, grant_idx;
    logic [NUM_REQ-1:0]      grant;
    logic [2:0]              cnt_q;
    logic [DATA_WIDTH-1:0]   opa_q, opb_q;
    logic [CMD_WIDTH-1:0]    cmd_q;
    logic                    mode_q, cin_q;
    logic [2*DATA_WIDTH-1:0] data_q;
    logic                    arb_en, hs;

    // Gating with rst keeps every output at zero while reset is asserted.
    assign arb_en = (state_q == StIdle) && !rst;

    alu_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign hs        = |grant;  // a grant is only ever given to a valid requester

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (hs) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (cnt_q == 3'd1) state_d = StResp;
            StResp:  if (resp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cmd_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            idx_q   <= '0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                opa_q  <= req_opa[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                opb_q  <= req_opb[grant_idx*DATA_WIDTH +: DATA_WIDTH];
                cmd_q  <= req_cmd[grant_idx*CMD_WIDTH +: CMD_WIDTH];
                mode_q <= req_mode[grant_idx];
                cin_q  <= req_cin[grant_idx];
                idx_q  <= grant_idx;
            end
            if (state_q == StIssue) begin
                cnt_q <= lat_sel(mode_q, 16'(cmd_q), ALU_LAT, MUL_LAT);
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q - 3'd1;
            end
            // res is valid in the last WAIT cycle; capture at full width.
            if (state_q == StWait && cnt_q == 3'd1) begin
                data_q <= alu_res;
                id_q   <= idx_q;
            end
            if (state_q == StResp && resp_ready) begin
                ptr_q <= idx_q;
            end
        end
    end

    assign alu_ce        = (state_q == StIssue) && !rst;
    assign alu_inp_valid = {2{alu_ce}};
    assign alu_opa       = opa_q;
    assign alu_opb       = opb_q;
    assign alu_cmd       = cmd_q;
    assign alu_mode      = mode_q;
    assign alu_cin       = cin_q;
    assign resp_valid    = (state_q == StResp) && !rst;
    assign resp_id       = id_q;
    assign resp_data     = data_q;

`ifdef ALU_SCHED_PERF_EN
    logic [31:0] ops_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            if (resp_valid && resp_ready)  ops_q   <= ops_q + 32'd1;
            if (resp_valid && !resp_ready) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_ops   = ops_q;
    assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
module tb_alu_req_scheduler;
    localparam int N       = 4;
    localparam int DW      = 8;
    localparam int CW      = 4;
    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready;
    logic [N*DW-1:0]   req_opa, req_opb;
    logic [N*CW-1:0]   req_cmd;
    logic [N-1:0]      req_mode, req_cin;
    logic              alu_ce;
    logic [1:0]        alu_inp_valid;
    logic [DW-1:0]     alu_opa, alu_opb;
    logic [CW-1:0]     alu_cmd;
    logic              alu_mode, alu_cin;
    logic [2*DW-1:0]   alu_res;
    logic              resp_valid, resp_ready;
    logic [1:0]        resp_id;
    logic [2*DW-1:0]   resp_data;

    int total = 0;
    int bad   = 0;

    // Stimulus copies of each requester's fields (bench side, never read from DUT).
    logic [DW-1:0] fa [N];
    logic [DW-1:0] fb [N];
    logic [CW-1:0] fc [N];
    logic          fm [N];
    logic          fi [N];

    always #5 clk = ~clk;

    alu_req_scheduler #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .CMD_WIDTH  (CW),
        .ALU_LAT    (ALU_LAT),
        .MUL_LAT    (MUL_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opa       (req_opa),
        .req_opb       (req_opb),
        .req_cmd       (req_cmd),
        .req_mode      (req_mode),
        .req_cin       (req_cin),
        .alu_ce        (alu_ce),
        .alu_inp_valid (alu_inp_valid),
        .alu_opa       (alu_opa),
        .alu_opb       (alu_opb),
        .alu_cmd       (alu_cmd),
        .alu_mode      (alu_mode),
        .alu_cin       (alu_cin),
        .alu_res       (alu_res),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_data     (resp_data)
    );

    // Toy ALU behaviour; only needs to be deterministic and field-sensitive.
    function automatic logic [2*DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [CW-1:0] c, input logic m,
                                               input logic ci);
        if (m && c == 4'd0) return 16'(a) + 16'(b) + 16'(ci);
        if (m && (c == 4'd9 || c == 4'd10)) return 16'(a) * 16'(b);
        return {c, 3'b101, ci, a ^ b};
    endfunction

    function automatic int lat_of(input logic m, input logic [CW-1:0] c);
        return (m && (c == 4'd9 || c == 4'd10)) ? MUL_LAT : ALU_LAT;
    endfunction

    // Next requester after p (wrapping) that is valid, or -1.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // ALU environment: result is valid only LAT cycles after the ce edge, garbage otherwise.
    logic [2*DW-1:0] pend_q;
    int              rem_q = 0;
    always @(posedge clk) begin
        if (alu_ce === 1'b1) begin
            pend_q  <= alu_fn(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin);
            rem_q   <= lat_of(alu_mode, alu_cmd) - 1;
            alu_res <= (lat_of(alu_mode, alu_cmd) == 1) ?
                       alu_fn(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin) : 16'($urandom);
        end else if (rem_q > 0) begin
            rem_q   <= rem_q - 1;
            alu_res <= (rem_q == 1) ? pend_q : 16'($urandom);
        end else begin
            alu_res <= 16'($urandom);
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [CW-1:0] c, input logic m, input logic ci);
        fa[i] = a; fb[i] = b; fc[i] = c; fm[i] = m; fi[i] = ci;
        req_opa[i*DW +: DW] = a;
        req_opb[i*DW +: DW] = b;
        req_cmd[i*CW +: CW] = c;
        req_mode[i]         = m;
        req_cin[i]          = ci;
    endtask

    task automatic do_reset;
        rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = '1; resp_ready = 1'b1;
        tick; tick; #1;
        total++;
        if ({req_ready, alu_ce, alu_inp_valid, resp_valid} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: ready=%b ce=%b iv=%b rv=%b want all 0",
                     req_ready, alu_ce, alu_inp_valid, resp_valid);
        end
        total++;
        if ({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin} !== '0) begin
            bad++;
            $display("FAIL reset_alu_ports: opa=%h opb=%h cmd=%h mode=%b cin=%b want 0",
                     alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin);
        end
        total++;
        if ({resp_id, resp_data} !== '0) begin
            bad++;
            $display("FAIL reset_resp: id=%0d data=%h want 0", resp_id, resp_data);
        end
        req_valid = '0; rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick; #1;
            total++;
            if (alu_ce !== 1'b0 || req_ready !== '0) begin
                bad++;
                $display("FAIL idle_quiet: cycle %0d ce=%b ready=%b want 0", c, alu_ce, req_ready);
            end
        end
    endtask

    task automatic test_single_add;
        do_reset;
        set_req(2, 8'h0F, 8'h01, 4'd0, 1'b1, 1'b0);
        req_valid = 4'b0100; #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++; $display("FAIL add_grant: ready=%b want 0100", req_ready);
        end
        tick; req_valid = '0; #1;
        total++;
        if (alu_ce !== 1'b1 || alu_inp_valid !== 2'b11 || alu_opa !== 8'h0F ||
            alu_opb !== 8'h01 || alu_cmd !== 4'd0 || alu_mode !== 1'b1 || alu_cin !== 1'b0) begin
            bad++;
            $display("FAIL add_issue: ce=%b iv=%b opa=%h opb=%h cmd=%h mode=%b want 1 11 0f 01 0 1",
                     alu_ce, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode);
        end
        tick; #1;
        total++;
        if (alu_ce !== 1'b0 || alu_inp_valid !== 2'b00 || resp_valid !== 1'b0 ||
            alu_opa !== 8'h0F) begin
            bad++;
            $display("FAIL add_wait: ce=%b iv=%b rv=%b opa=%h want 0 00 0 0f",
                     alu_ce, alu_inp_valid, resp_valid, alu_opa);
        end
        tick; #1;
        total++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 16'h0010) begin
            bad++;
            $display("FAIL add_resp: rv=%b id=%0d data=%h want 1 2 0010",
                     resp_valid, resp_id, resp_data);
        end
        resp_ready = 1'b1;
        tick; resp_ready = 1'b0; #1;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++; $display("FAIL add_accept: rv=%b want 0", resp_valid);
        end
    endtask

    task automatic test_mul_latency;
        do_reset;
        for (int m = 1; m >= 0; m--) begin
            int n;
            int want;
            logic [2*DW-1:0] exp;
            want = (m == 1) ? MUL_LAT + 2 : ALU_LAT + 2;
            set_req(0, 8'($urandom), 8'($urandom), 4'd9, m[0], 1'($urandom));
            exp = alu_fn(fa[0], fb[0], fc[0], fm[0], fi[0]);
            req_valid = 4'b0001; resp_ready = 1'b1; #1;
            total++;
            if (req_ready !== 4'b0001) begin
                bad++; $display("FAIL mul_grant: mode=%0d ready=%b want 0001", m, req_ready);
            end
            tick; req_valid = '0; n = 1; #1;
            while (resp_valid !== 1'b1 && n < 30) begin
                tick; #1; n++;
            end
            total++;
            if (n !== want) begin
                bad++; $display("FAIL mul_latency: mode=%0d resp after %0d want %0d", m, n, want);
            end
            total++;
            if (resp_data !== exp || resp_id !== 2'd0) begin
                bad++;
                $display("FAIL mul_data: mode=%0d id=%0d data=%h want 0 %h",
                         m, resp_id, resp_data, exp);
            end
            tick;
        end
        resp_ready = 1'b0;
    endtask

    // Holds a fixed request set and checks grant order, ce pulses and handshake spacing.
    task automatic test_round_robin;
        int ngr, cyc, last, ces, exp_id;
        do_reset;
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom), 4'd0, 1'b1,
                                            1'($urandom));
        req_valid = 4'hF; resp_ready = 1'b1;
        ngr = 0; cyc = 0; last = 0; ces = 0; exp_id = 0;
        while (ngr < 6 && cyc < 200) begin
            #1;
            if (alu_ce === 1'b1) ces++;
            if (resp_valid === 1'b1) begin
                total++;
                if (resp_id !== 2'(exp_id) ||
                    resp_data !== alu_fn(fa[exp_id], fb[exp_id], fc[exp_id], fm[exp_id],
                                         fi[exp_id])) begin
                    bad++;
                    $display("FAIL rr_resp: id=%0d data=%h want id %0d", resp_id, resp_data,
                             exp_id);
                end
            end
            if (req_ready !== '0) begin
                total++;
                if (req_ready !== 4'(1 << (ngr % N))) begin
                    bad++;
                    $display("FAIL rr_order: grant #%0d ready=%b want %b", ngr, req_ready,
                             4'(1 << (ngr % N)));
                end
                if (ngr > 0) begin
                    total++;
                    if (ces !== 1) begin
                        bad++; $display("FAIL rr_ce_pulses: %0d between grants want 1", ces);
                    end
                    total++;
                    if (cyc - last !== ALU_LAT + 3) begin
                        bad++;
                        $display("FAIL rr_gap: %0d cycles want %0d", cyc - last, ALU_LAT + 3);
                    end
                end
                ces = 0; last = cyc; exp_id = ngr % N; ngr++;
            end
            tick; cyc++;
        end
        total++;
        if (ngr !== 6) begin
            bad++; $display("FAIL rr_timeout: %0d grants want 6", ngr);
        end
        req_valid = '0; resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int ngr, cyc, last;
        do_reset;
        set_req(3, 8'h55, 8'hAA, 4'd9, 1'b0, 1'b1);
        req_valid = 4'b1000; resp_ready = 1'b1;
        ngr = 0; cyc = 0; last = 0;
        while (ngr < 4 && cyc < 100) begin
            #1;
            if (req_ready !== '0) begin
                total++;
                if (req_ready !== 4'b1000 || (ngr > 0 && cyc - last !== ALU_LAT + 3)) begin
                    bad++;
                    $display("FAIL b2b_grant: ready=%b gap=%0d want 1000 gap %0d",
                             req_ready, cyc - last, ALU_LAT + 3);
                end
                last = cyc; ngr++;
            end
            tick; cyc++;
        end
        total++;
        if (ngr !== 4) begin
            bad++; $display("FAIL b2b_timeout: %0d grants want 4", ngr);
        end
        req_valid = '0; resp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int n;
        logic [2*DW-1:0] exp;
        do_reset;
        set_req(1, 8'hC3, 8'h3C, 4'd5, 1'b0, 1'b1);
        exp = alu_fn(fa[1], fb[1], fc[1], fm[1], fi[1]);
        req_valid = 4'b0010; resp_ready = 1'b0; #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL bp_grant: ready=%b want 0010", req_ready);
        end
        tick;
        set_req(0, 8'h11, 8'h22, 4'd0, 1'b1, 1'b0);
        req_valid = 4'b0001; n = 0; #1;
        while (resp_valid !== 1'b1 && n < 30) begin
            tick; #1; n++;
        end
        for (int k = 0; k < 10; k++) begin
            total++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== exp ||
                alu_ce !== 1'b0 || req_ready !== '0) begin
                bad++;
                $display("FAIL bp_stall: k=%0d rv=%b id=%0d data=%h ce=%b ready=%b want 1 1 %h 0 0",
                         k, resp_valid, resp_id, resp_data, alu_ce, req_ready, exp);
            end
            tick; #1;
        end
        resp_ready = 1'b1;
        tick; resp_ready = 1'b0; #1;
        total++;
        if (resp_valid !== 1'b0 || req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL bp_release: rv=%b ready=%b want 0 0001", resp_valid, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_midop;
        do_reset;
        set_req(0, 8'h01, 8'h02, 4'd0, 1'b1, 1'b0);
        req_valid = 4'b0001; resp_ready = 1'b1;
        tick; req_valid = '0;
        repeat (4) tick;
        set_req(1, 8'h07, 8'h09, 4'd9, 1'b1, 1'b0);
        req_valid = 4'b0010; #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++; $display("FAIL midop_grant: ready=%b want 0010", req_ready);
        end
        tick; req_valid = '0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            total++;
            if (resp_valid !== 1'b0 || alu_ce !== 1'b0) begin
                bad++;
                $display("FAIL midop_no_resp: cycle %0d rv=%b ce=%b want 0 0", c, resp_valid,
                         alu_ce);
            end
            tick;
        end
        set_req(0, 8'h33, 8'h44, 4'd0, 1'b1, 1'b0);
        req_valid = 4'b0011; #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++; $display("FAIL midop_ptr: ready=%b want 0001", req_ready);
        end
        tick; req_valid = '0;
        repeat (6) tick;
        resp_ready = 1'b0;
    endtask

    // Random valids, fields and backpressure against a transaction-level model.
    task automatic test_random;
        int mptr, hs_c, lat, id, w;
        bit busy, exp_ce, exp_rv;
        logic [N-1:0] exp_rr;
        logic [DW-1:0] ea, eb;
        logic [CW-1:0] ec;
        logic em, ei;
        do_reset;
        mptr = N - 1; busy = 0; hs_c = 0; lat = 1; id = 0;
        ea = '0; eb = '0; ec = '0; em = 1'b0; ei = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                logic [CW-1:0] cc;
                case ($urandom % 4)
                    0:       cc = 4'd0;
                    1:       cc = 4'd9;
                    2:       cc = 4'd10;
                    default: cc = 4'($urandom);
                endcase
                set_req(i, 8'($urandom), 8'($urandom), cc, 1'($urandom), 1'($urandom));
            end
            req_valid  = (($urandom % 3) == 0) ? 4'($urandom) : 4'($urandom) & 4'($urandom);
            resp_ready = ($urandom % 4) != 0;
            #1;
            exp_ce = busy && (c == hs_c + 1);
            exp_rv = busy && (c >= hs_c + 2 + lat);
            total++;
            if (alu_ce !== exp_ce || alu_inp_valid !== {2{exp_ce}}) begin
                bad++; $display("FAIL rnd_ce: c=%0d ce=%b iv=%b want %b", c, alu_ce,
                                alu_inp_valid, exp_ce);
            end
            if (exp_ce) begin
                total++;
                if (alu_opa !== ea || alu_opb !== eb || alu_cmd !== ec || alu_mode !== em ||
                    alu_cin !== ei) begin
                    bad++;
                    $display("FAIL rnd_alu_ports: c=%0d got %h %h %h %b %b want %h %h %h %b %b",
                             c, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, ea, eb, ec, em, ei);
                end
            end
            total++;
            if (resp_valid !== exp_rv) begin
                bad++; $display("FAIL rnd_resp_valid: c=%0d rv=%b want %b", c, resp_valid, exp_rv);
            end
            if (exp_rv) begin
                total++;
                if (resp_id !== 2'(id) || resp_data !== alu_fn(ea, eb, ec, em, ei)) begin
                    bad++;
                    $display("FAIL rnd_resp: c=%0d id=%0d data=%h want %0d %h", c, resp_id,
                             resp_data, id, alu_fn(ea, eb, ec, em, ei));
                end
            end
            exp_rr = '0;
            w = busy ? -1 : rr_pick(req_valid, mptr);
            if (w >= 0) exp_rr[w] = 1'b1;
            total++;
            if (req_ready !== exp_rr) begin
                bad++; $display("FAIL rnd_ready: c=%0d ready=%b want %b", c, req_ready, exp_rr);
            end
            if (exp_rv && resp_ready) begin
                busy = 0; mptr = id;
            end else if (w >= 0) begin
                busy = 1; hs_c = c; id = w;
                ea = fa[w]; eb = fb[w]; ec = fc[w]; em = fm[w]; ei = fi[w];
                lat = lat_of(em, ec);
            end
            tick;
        end
        req_valid = '0; resp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
        req_opa = '0; req_opb = '0; req_cmd = '0; req_mode = '0; req_cin = '0;
        test_reset;
        test_single_add;
        test_mul_latency;
        test_round_robin;
        test_back_to_back;
        test_backpressure;
        test_reset_midop;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one ALU instance between NUM_REQ requesters.
- Each requester presents a complete operation (opa, opb, cmd, mode, cin) over a valid/ready handshake.
- The scheduler arbitrates round-robin, drives the ALU input ports for a single issue cycle, and waits the command-dependent ALU latency with ce held low so the result stays stable.
- It captures res and returns it to the granted requester, tagged with its index, over a valid/ready response handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, operand width (matches `DATA_WIDTH).
- CMD_WIDTH, 4, command width (matches `CMD_WIDTH).
- ALU_LAT, 1, cycles from issue (ce=1) to valid res for non-multiply commands (1..7).
- MUL_LAT, 2, same for multiply commands (mode=1, cmd 9 or 10) (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operation valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_opa  in  NUM_REQ*DATA_WIDTH  packed operand A, slice i belongs to requester i
- req_opb  in  NUM_REQ*DATA_WIDTH  packed operand B
- req_cmd  in  NUM_REQ*CMD_WIDTH  packed command
- req_mode  in  NUM_REQ  packed mode (1 = arithmetic, 0 = logical)
- req_cin  in  NUM_REQ  packed carry-in
- alu_ce  out  1  ALU clock enable
- alu_inp_valid  out  2  ALU operand-valid
- alu_opa / alu_opb  out  DATA_WIDTH  ALU operands
- alu_cmd  out  CMD_WIDTH  ALU command
- alu_mode  out  1  ALU mode
- alu_cin  out  1  ALU carry-in
- alu_res  in  2*DATA_WIDTH  ALU result
- resp_valid  out  1  result available
- resp_ready  in  1  result consumer accept
- resp_id  out  $clog2(NUM_REQ)  index of the requester that owns resp_data
- resp_data  out  2*DATA_WIDTH  captured result

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE; ptr=NUM_REQ-1, so requester 0 has first priority; counter=0.
  - All outputs 0: req_ready, alu_ce, alu_inp_valid, alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, resp_valid, resp_id, resp_data.
  - Reset mid-operation abandons the in-flight op; no response is produced.
- State machine:
  - IDLE: the winner is the first asserted req_valid searching ptr+1, ptr+2, ... modulo NUM_REQ. req_ready[winner]=1 combinationally in that cycle and 0 for all others. The handshake latches the winner's fields and index; next state is ISSUE. With no req_valid, stay in IDLE.
  - ISSUE (exactly 1 cycle): alu_ce=1, alu_inp_valid=2'b11, ALU ports driven from the latched fields. counter is loaded with LAT = (mode && (cmd==9 || cmd==10)) ? MUL_LAT : ALU_LAT. Next state is WAIT.
  - WAIT: alu_ce=0, alu_inp_valid=2'b00; ALU data ports hold their last values. counter decrements each cycle. When counter==1, resp_data<=alu_res and resp_id<=latched index, and the next state is RESP.
  - RESP: resp_valid=1; resp_data and resp_id are held stable until resp_ready. The cycle with resp_valid && resp_ready sets ptr<=granted index and returns to IDLE.
- req_ready is 0 outside IDLE: one operation in flight at a time, no new grant during ISSUE, WAIT or RESP.
- Latency: handshake at cycle T, alu_ce at T+1, res sampled at T+1+LAT, resp_valid from T+2+LAT. Minimum handshake-to-handshake gap is LAT+3 cycles.
- Boundaries:
  - All requesters valid: grants rotate 0,1,2,3,0,...
  - A single requester holding req_valid is granted back-to-back.
  - A requester dropping req_valid before its grant is simply skipped; no requirement is placed on requesters.
  - resp_ready held low: the scheduler stalls indefinitely in RESP with outputs stable.
  - ptr wraps NUM_REQ-1 -> 0.
- Width rules:
  - The latched fields, and therefore alu_* and resp_data, come from the winner's packed slice.
  - The result is captured at full 2*DATA_WIDTH; no truncation.

Optional Feature:
- Macro ALU_SCHED_PERF_EN.
- Defined: adds outputs perf_ops (32 bits, increments on each response handshake) and perf_stall (32 bits, increments each cycle in RESP with resp_ready=0). Both clear on rst and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_sched_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, RESP;
  - constants CMD_MUL_INC=4'd9 and CMD_MUL_SHIFT=4'd10;
  - function lat_sel(mode, cmd, ALU_LAT, MUL_LAT).
- Sub-module alu_rr_arbiter: parameter NUM_REQ; inputs req vector, ptr, enable; output one-hot grant and grant index. Purely combinational; ptr is stored in the parent.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0; after release with no req_valid, alu_ce stays 0 for 20 cycles.
- Single ADD: req 2, opa=8'h0F, opb=8'h01, cmd=0, mode=1, ALU_LAT=1 -> alu_ce one cycle after handshake; resp_id=2 and resp_data=16'h0010 three cycles after handshake.
- Multiply latency: req 0, cmd=9, mode=1, MUL_LAT=2 -> resp_valid four cycles after handshake. Same cmd with mode=0 uses ALU_LAT: three cycles.
- Round-robin fairness: all four req_valid held high, responses always accepted -> grant order 0,1,2,3,0,1. Each grant coincides with exactly one alu_ce pulse.
- Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_data, resp_id, alu_ce=0 and req_ready=0 stable throughout; the next grant follows only after acceptance.
- Reset mid-op: assert rst during WAIT -> no response ever appears; after release, req 1 is granted first even if req 0 is also valid? No: with ptr reset to NUM_REQ-1, requester 0 wins.
